// File: rtl/compare_pkg.sv
// Shared types and width helpers for the chunked comparator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package compare_pkg;

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // Index width; a single-chunk configuration still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Cycle counter must hold the value NCHUNK itself, hence the extra bit.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/chunk_select.sv
// Extracts chunk idx (bits [idx*CHUNK +: CHUNK]) from a WIDTH-bit vector.
// Latency: combinational.
// Backpressure: none.
// Ports: data (WIDTH) in, idx (chunk index) in, chunk (CHUNK) out.
module chunk_select import compare_pkg::*; #(
    parameter  int WIDTH  = 8,
    parameter  int CHUNK  = 2,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int IDXW   = idx_w(NCHUNK)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [IDXW-1:0]  idx,
    output logic [CHUNK-1:0] chunk
);

    // Explicit mux over legal indices keeps out-of-range indices at zero.
    always_comb begin
        chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IDXW'(k)) begin
                chunk = data[k*CHUNK +: CHUNK];
            end
        end
    end

endmodule

// File: rtl/chunk_compare.sv
// Compares two WIDTH-bit operands CHUNK bits per cycle, LSB chunk first;
// Latency: 1 cycle to capture, then 1..NCHUNK COMPARE cycles (early exit or full scan).
// Backpressure: none; start is honoured only in WAIT, restart always wins.
// Ports: clk, rst (async, active-high), start, restart, const_time,
//        correct_value/guessed_value (WIDTH) in; busy, success, fail,
//        mismatch_idx, cycle_count, debug_idx out.
// Build option: CHUNK_COMPARE_CONST_TIME_EN enables the constant-time scan mode.
module chunk_compare import compare_pkg::*; #(
    parameter  int WIDTH  = 8,
    parameter  int CHUNK  = 2,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int IDXW   = idx_w(NCHUNK),
    localparam int CNTW   = cnt_w(NCHUNK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             restart,
    input  logic             const_time,
    input  logic [WIDTH-1:0] correct_value,
    input  logic [WIDTH-1:0] guessed_value,
    output logic             busy,
    output logic             success,
    output logic             fail,
    output logic [IDXW-1:0]  mismatch_idx,
    output logic [CNTW-1:0]  cycle_count,
    output logic [IDXW-1:0]  debug_idx
);

    if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("chunk_compare: WIDTH must be a multiple of CHUNK");
    end

    state_t            state, state_d;
    logic [WIDTH-1:0]  cap_correct, cap_guess;
    logic [CHUNK-1:0]  chunk_c, chunk_g;
    logic              chunk_mismatch, last_chunk;
    logic              early_exit, any_mismatch, record_idx;
    logic              set_fail, set_success;

    chunk_select #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_sel_correct (
        .data  (cap_correct),
        .idx   (debug_idx),
        .chunk (chunk_c)
    );

    chunk_select #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_sel_guess (
        .data  (cap_guess),
        .idx   (debug_idx),
        .chunk (chunk_g)
    );

    assign chunk_mismatch = (chunk_c != chunk_g);
    assign last_chunk     = (debug_idx == IDXW'(NCHUNK - 1));

`ifdef CHUNK_COMPARE_CONST_TIME_EN
    logic cap_ct;
    logic mm_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_ct  <= 1'b0;
            mm_seen <= 1'b0;
        end else if (restart) begin
            mm_seen <= 1'b0;
        end else if (state == S_WAIT && start) begin
            cap_ct  <= const_time;
            mm_seen <= 1'b0;
        end else if (state == S_COMPARE && chunk_mismatch) begin
            mm_seen <= 1'b1;
        end
    end

    assign early_exit   = !cap_ct;
    assign any_mismatch = mm_seen | chunk_mismatch;
    // Only the first mismatching chunk index is kept during a full scan.
    assign record_idx   = chunk_mismatch && !mm_seen;
`else
    logic unused_const_time;
    assign unused_const_time = const_time;
    assign early_exit   = 1'b1;
    assign any_mismatch = chunk_mismatch;
    assign record_idx   = chunk_mismatch;
`endif

    always_comb begin
        state_d     = state;
        set_fail    = 1'b0;
        set_success = 1'b0;
        case (state)
            S_WAIT: begin
                if (start) state_d = S_COMPARE;
            end
            S_COMPARE: begin
                if (early_exit && chunk_mismatch) begin
                    state_d  = S_DONE;
                    set_fail = 1'b1;
                end else if (last_chunk) begin
                    state_d     = S_DONE;
                    set_fail    = any_mismatch;
                    set_success = !any_mismatch;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_WAIT;
        endcase
        if (restart) state_d = S_WAIT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_WAIT;
            busy         <= 1'b0;
            success      <= 1'b0;
            fail         <= 1'b0;
            mismatch_idx <= '0;
            cycle_count  <= '0;
            debug_idx    <= '0;
            cap_correct  <= '0;
            cap_guess    <= '0;
        end else begin
            state <= state_d;
            busy  <= (state_d == S_COMPARE);
            if (restart) begin
                success      <= 1'b0;
                fail         <= 1'b0;
                mismatch_idx <= '0;
                cycle_count  <= '0;
                debug_idx    <= '0;
            end else begin
                case (state)
                    S_WAIT: begin
                        if (start) begin
                            cap_correct <= correct_value;
                            cap_guess   <= guessed_value;
                            cycle_count <= '0;
                            debug_idx   <= '0;
                        end
                    end
                    S_COMPARE: begin
                        // At most NCHUNK COMPARE cycles, so this cannot wrap.
                        cycle_count <= cycle_count + 1'b1;
                        if (record_idx)  mismatch_idx <= debug_idx;
                        if (set_fail)    fail         <= 1'b1;
                        if (set_success) success      <= 1'b1;
                        if (state_d == S_COMPARE) debug_idx <= debug_idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chunk_compare.sv
module tb_chunk_compare;

    typedef struct {
        logic s;
        logic f;
        int   idx;
        int   cnt;
        int   nb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, restart;
    logic        start_a, ct_a, start_b, ct_b;
    logic [7:0]  c_a, g_a;
    logic [15:0] c_b, g_b;
    logic        busy_a, succ_a, fail_a, busy_b, succ_b, fail_b;
    logic [1:0]  midx_a, dbg_a, midx_b, dbg_b;
    logic [2:0]  cnt_a, cnt_b;

    logic        sel_b;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    chunk_compare #(.WIDTH(8), .CHUNK(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .restart(restart),
        .const_time(ct_a), .correct_value(c_a), .guessed_value(g_a),
        .busy(busy_a), .success(succ_a), .fail(fail_a),
        .mismatch_idx(midx_a), .cycle_count(cnt_a), .debug_idx(dbg_a)
    );

    chunk_compare #(.WIDTH(16), .CHUNK(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .restart(restart),
        .const_time(ct_b), .correct_value(c_b), .guessed_value(g_b),
        .busy(busy_b), .success(succ_b), .fail(fail_b),
        .mismatch_idx(midx_b), .cycle_count(cnt_b), .debug_idx(dbg_b)
    );

    wire       s_busy = sel_b ? busy_b : busy_a;
    wire       s_succ = sel_b ? succ_b : succ_a;
    wire       s_fail = sel_b ? fail_b : fail_a;
    wire [1:0] s_midx = sel_b ? midx_b : midx_a;
    wire [1:0] s_dbg  = sel_b ? dbg_b  : dbg_a;
    wire [2:0] s_cnt  = sel_b ? cnt_b  : cnt_a;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, s_busy, 0);
        chk({tag, "_succ"}, s_succ, 0);
        chk({tag, "_fail"}, s_fail, 0);
        chk({tag, "_midx"}, s_midx, 0);
        chk({tag, "_cnt"},  s_cnt,  0);
        chk({tag, "_dbg"},  s_dbg,  0);
    endtask

    task automatic pulse_start(input logic wide);
        if (wide) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // One full comparison: push expectation, start, wait for result,
    // check result, check DONE ignores start, then restart back to WAIT.
    task automatic run(input logic wide, input logic [15:0] c, input logic [15:0] g,
                       input logic ct, input logic corrupt, input string tag,
                       input logic es, input logic ef, input int eidx,
                       input int ecnt, input int enb);
        exp_t e;
        exp_t got;
        int   nb;
        int   guard;
        e.s = es; e.f = ef; e.idx = eidx; e.cnt = ecnt; e.nb = enb;
        sb.push_back(e);
        sel_b = wide;
        if (wide) begin
            c_b = c; g_b = g; ct_b = ct;
        end else begin
            c_a = c[7:0]; g_a = g[7:0]; ct_a = ct;
        end
        pulse_start(wide);
        if (corrupt) begin
            g_a = 8'h00;
            g_b = 16'h0000;
        end
        nb = 0;
        guard = 0;
        while (!(s_succ || s_fail) && guard < 40) begin
            if (s_busy) nb++;
            guard++;
            tick();
        end
        got = sb.pop_front();
        chk({tag, "_done"}, (s_succ || s_fail), 1);
        chk({tag, "_succ"}, s_succ, got.s);
        chk({tag, "_fail"}, s_fail, got.f);
        chk({tag, "_midx"}, s_midx, got.idx);
        chk({tag, "_cnt"},  s_cnt,  got.cnt);
        chk({tag, "_nbusy"}, nb, got.nb);
        chk({tag, "_busy_done"}, s_busy, 0);
        pulse_start(wide);
        chk({tag, "_hold_succ"}, s_succ, got.s);
        chk({tag, "_hold_cnt"},  s_cnt,  got.cnt);
        chk({tag, "_hold_busy"}, s_busy, 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk_idle({tag, "_rs"});
    endtask

    initial begin
        rst = 1'b1; restart = 1'b0; sel_b = 1'b0;
        start_a = 1'b0; ct_a = 1'b0; c_a = '0; g_a = '0;
        start_b = 1'b0; ct_b = 1'b0; c_b = '0; g_b = '0;
        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();

        run(0, 16'h00A5, 16'h00A5, 0, 0, "match",   1, 0, 0, 4, 4);
        run(0, 16'h00A5, 16'h00A4, 0, 0, "mm0",     0, 1, 0, 1, 1);
`ifdef CHUNK_COMPARE_CONST_TIME_EN
        run(0, 16'h00A5, 16'h00A4, 1, 0, "ct_mm0",  0, 1, 0, 4, 4);
        run(0, 16'h00A5, 16'h0025, 1, 0, "ct_mm3",  0, 1, 3, 4, 4);
        run(0, 16'h00A5, 16'h00A5, 1, 0, "ct_match", 1, 0, 0, 4, 4);
`endif
        run(0, 16'h00A5, 16'h0025, 0, 0, "mm3",     0, 1, 3, 4, 4);
        run(0, 16'h00A5, 16'h00A5, 0, 1, "capture", 1, 0, 0, 4, 4);
        run(1, 16'h1234, 16'h1F34, 0, 0, "w16",     0, 1, 2, 3, 3);

        // restart during the second COMPARE cycle
        sel_b = 1'b0;
        c_a = 8'hA5; g_a = 8'hA5; ct_a = 1'b0;
        pulse_start(0);
        tick();
        chk("mid_busy", s_busy, 1);
        chk("mid_cnt", s_cnt, 1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk_idle("restart_mid");
        tick();
        tick();
        chk("restart_stays_wait", s_busy, 0);

        // asynchronous reset mid-comparison, no clock edge in between
        pulse_start(0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk_idle("async_rst");
        @(negedge clk);
        rst = 1'b0;
        tick();
        run(0, 16'h00A5, 16'h00A5, 0, 0, "after_rst", 1, 0, 0, 4, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
